// File: rtl/regbank_arbiter_if.sv
// Instruction-port bundle between the two requesters, the arbiter and the bank.
interface regbank_arbiter_if #(
   parameter int INST_WIDTH = 12
);
   logic                  req0;
   logic [INST_WIDTH-1:0] inst0;
   logic                  ack0;
   logic                  req1;
   logic [INST_WIDTH-1:0] inst1;
   logic                  ack1;
   logic [INST_WIDTH-1:0] inst;
   logic                  inst_en;
   logic                  grant;
   logic                  error;

   modport master (
      output req0, inst0, req1, inst1,
      input  ack0, ack1, inst, inst_en, grant, error
   );

   modport slave (
      input  req0, inst0, req1, inst1,
      output ack0, ack1, inst, inst_en, grant, error
   );
endinterface

// File: rtl/regbank_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one register-bank instruction port;
// illegal opcodes are swallowed and park the block in a sticky error state.
module regbank_arbiter #(
   parameter int INST_WIDTH = 12,
   parameter int MAX_BURST  = 4,
   parameter int CODE_MAX   = 3
) (
   input  logic clock,
   input  logic reset,
   regbank_arbiter_if.slave bus
);
   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_READY = 2'd1;
   localparam logic [1:0] S_ERROR = 2'd2;

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
   localparam logic [3:0] CODE_LIM  = 4'(CODE_MAX);

   logic [1:0]            state_q, state_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  inst_en_q, inst_en_d;
   logic                  grant_q, grant_d;
   logic                  error_q, error_d;
   logic                  prio_q, prio_d;
   logic                  owner_q, owner_d;
   logic [3:0]            cnt_q, cnt_d;

   logic                  sel_any;
   logic                  sel_n;
   logic                  owner_req;
   logic [INST_WIDTH-1:0] sel_inst;
   logic [3:0]            opcode;
   logic                  legal;

   assign owner_req = owner_q ? bus.req1 : bus.req0;

   // Burst continuation beats round-robin until the owner uses up its budget.
   always_comb begin
      sel_any = 1'b0;
      sel_n   = 1'b0;
      if (state_q == S_READY) begin
         if (owner_req && (cnt_q < BURST_LIM)) begin
            sel_any = 1'b1;
            sel_n   = owner_q;
         end else if (bus.req0 ^ bus.req1) begin
            sel_any = 1'b1;
            sel_n   = bus.req1;
         end else if (bus.req0 && bus.req1) begin
            sel_any = 1'b1;
            sel_n   = prio_q;
         end
      end
   end

   assign sel_inst = sel_n ? bus.inst1 : bus.inst0;
   assign opcode   = sel_inst[INST_WIDTH-1 -: 4];
   assign legal    = (opcode <= CODE_LIM);

   assign bus.ack0 = reset && sel_any && !sel_n;
   assign bus.ack1 = reset && sel_any && sel_n;

   always_comb begin
      state_d   = state_q;
      inst_d    = '0;
      inst_en_d = 1'b0;
      grant_d   = grant_q;
      error_d   = error_q;
      prio_d    = prio_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         S_RESET: begin
            state_d = S_READY;
         end
         S_READY: begin
            if (sel_any && legal) begin
               inst_d    = sel_inst;
               inst_en_d = 1'b1;
               grant_d   = sel_n;
               owner_d   = sel_n;
               prio_d    = ~sel_n;
               // An exhausted burst restarts at 1 when re-granted.
               if ((sel_n == owner_q) && inst_en_q
                   && (cnt_q < BURST_LIM))
                  cnt_d = cnt_q + 4'd1;
               else
                  cnt_d = 4'd1;
            end else if (sel_any) begin
               state_d = S_ERROR;
               error_d = 1'b1;
            end else begin
               cnt_d = 4'd0;
            end
         end
         S_ERROR: begin
            error_d = 1'b1;
         end
         default: begin
            state_d = S_ERROR;
            error_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_RESET;
         inst_q    <= '0;
         inst_en_q <= 1'b0;
         grant_q   <= 1'b0;
         error_q   <= 1'b0;
         prio_q    <= 1'b0;
         owner_q   <= 1'b0;
         cnt_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         inst_en_q <= inst_en_d;
         grant_q   <= grant_d;
         error_q   <= error_d;
         prio_q    <= prio_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.inst    = inst_q;
   assign bus.inst_en = inst_en_q;
   assign bus.grant   = grant_q;
   assign bus.error   = error_q;
endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: reset, bursts, alternation,
// illegal opcode error and asynchronous reset with a pending request.
module tb_regbank_arbiter;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   regbank_arbiter_if #(.INST_WIDTH(12)) bus ();

   regbank_arbiter #(
      .INST_WIDTH(12),
      .MAX_BURST (4),
      .CODE_MAX  (3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic [11:0] i0,
                        input logic r1, input logic [11:0] i1);
      bus.req0  = r0;
      bus.inst0 = i0;
      bus.req1  = r1;
      bus.inst1 = i1;
   endtask

   task automatic cyc(input logic r0, input logic [11:0] i0,
                      input logic r1, input logic [11:0] i1,
                      input logic e0, input logic e1);
      drive(r0, i0, r1, i1);
      #1;
      chk("ack0", 16'(bus.ack0), 16'(e0));
      chk("ack1", 16'(bus.ack1), 16'(e1));
      @(posedge clock);
      #1;
   endtask

   task automatic outs(input string tag, input logic en,
                       input logic [11:0] ins, input logic g,
                       input logic err);
      chk({tag, ".inst_en"}, 16'(bus.inst_en), 16'(en));
      chk({tag, ".inst"},    16'(bus.inst),    16'(ins));
      chk({tag, ".grant"},   16'(bus.grant),   16'(g));
      chk({tag, ".error"},   16'(bus.error),   16'(err));
   endtask

   initial begin
      logic       g;
      logic [3:0] ar0;
      logic [3:0] ar1;
      logic [3:0] ag;
      total = 0;
      bad   = 0;
      clock = 1'b0;
      reset = 1'b0;
      drive(1'b1, 12'h2A5, 1'b0, 12'h000);
      #3;
      outs("rst", 1'b0, 12'h000, 1'b0, 1'b0);
      chk("rst.ack0", 16'(bus.ack0), 16'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      cyc(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
      outs("ready", 1'b0, 12'h000, 1'b0, 1'b0);

      cyc(1'b1, 12'h2A5, 1'b0, 12'h000, 1'b1, 1'b0);
      outs("single", 1'b1, 12'h2A5, 1'b0, 1'b0);

      cyc(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
      outs("idle0", 1'b0, 12'h000, 1'b0, 1'b0);

      for (int k = 0; k < 9; k++) begin
         g = !((k < 4) || (k == 8));
         cyc(1'b1, 12'h211, 1'b1, 12'h322, !g, g);
         outs($sformatf("burst%0d", k), 1'b1,
              g ? 12'h322 : 12'h211, g, 1'b0);
      end

      cyc(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
      outs("idle1", 1'b0, 12'h000, 1'b0, 1'b0);

      ar0 = 4'b0101;
      ar1 = 4'b1011;
      ag  = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         cyc(ar0[k], 12'h0A0, ar1[k], 12'h1B1, !ag[k], ag[k]);
         outs($sformatf("alt%0d", k), 1'b1,
              ag[k] ? 12'h1B1 : 12'h0A0, ag[k], 1'b0);
      end

      cyc(1'b0, 12'h000, 1'b1, 12'h4FF, 1'b0, 1'b1);
      chk("err.error",   16'(bus.error),   16'h1);
      chk("err.inst_en", 16'(bus.inst_en), 16'h0);
      chk("err.inst",    16'(bus.inst),    16'h0);

      cyc(1'b1, 12'h2A5, 1'b0, 12'h000, 1'b0, 1'b0);
      chk("sticky.error",   16'(bus.error),   16'h1);
      chk("sticky.inst_en", 16'(bus.inst_en), 16'h0);

      #2;
      reset = 1'b0;
      #1;
      outs("clr", 1'b0, 12'h000, 1'b0, 1'b0);
      chk("clr.ack0", 16'(bus.ack0), 16'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc(1'b1, 12'h2A5, 1'b0, 12'h000, 1'b0, 1'b0);
      outs("rearb0", 1'b0, 12'h000, 1'b0, 1'b0);
      cyc(1'b1, 12'h2A5, 1'b0, 12'h000, 1'b1, 1'b0);
      outs("rearb1", 1'b1, 12'h2A5, 1'b0, 1'b0);

      cyc(1'b1, 12'h301, 1'b0, 12'h000, 1'b1, 1'b0);
      outs("mb0", 1'b1, 12'h301, 1'b0, 1'b0);
      drive(1'b1, 12'h302, 1'b0, 12'h000);
      #2;
      reset = 1'b0;
      #1;
      outs("mbrst", 1'b0, 12'h000, 1'b0, 1'b0);
      chk("mbrst.ack0", 16'(bus.ack0), 16'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc(1'b1, 12'h302, 1'b0, 12'h000, 1'b0, 1'b0);
      outs("mb1", 1'b0, 12'h000, 1'b0, 1'b0);
      cyc(1'b1, 12'h302, 1'b0, 12'h000, 1'b1, 1'b0);
      outs("mb2", 1'b1, 12'h302, 1'b0, 1'b0);

      drive(1'b0, 12'h000, 1'b0, 12'h000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
